// File: rtl/dpram_copy_engine.sv
// Word-by-word copy engine driving one synchronous-read RAM port: each word is
// read, captured and written back at a new address, and the copied words are XORed.
module dpram_copy_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [ADDR_WIDTH:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] checksum,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    // Handshake: start is a level request sampled only in IDLE (there is no ready);
    // done is a one-cycle pulse that coincides with checksum becoming valid.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_CAP,
        ST_WR,
        ST_DONE
    } state_t;

    localparam logic [ADDR_WIDTH:0] IDX_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   src_q, src_d;
    logic [ADDR_WIDTH-1:0]   dst_q, dst_d;
    logic [ADDR_WIDTH:0]     len_q, len_d;
    logic [ADDR_WIDTH:0]     idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [DATA_WIDTH-1:0]   xsum_q, xsum_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [DATA_WIDTH-1:0]   checksum_q, checksum_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic                    ram_we_q, ram_we_d;

    logic [ADDR_WIDTH:0]     idx_next;
    logic [ADDR_WIDTH-1:0]   rd_addr_next;
    logic [ADDR_WIDTH-1:0]   wr_addr;

    assign idx_next     = idx_q + IDX_ONE;
    assign rd_addr_next = src_q + idx_next[ADDR_WIDTH-1:0];
    assign wr_addr      = dst_q + idx_q[ADDR_WIDTH-1:0];

    // Outputs are registered, so each RAM-side value is computed on the edge
    // that enters the state in which it must be visible.
    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        len_d      = len_q;
        idx_d      = idx_q;
        data_d     = data_q;
        xsum_d     = xsum_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        checksum_d = checksum_q;
        ram_addr_d = ram_addr_q;
        ram_we_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_d    = ST_DONE;
                        xsum_d     = '0;
                        checksum_d = '0;
                        done_d     = 1'b1;
                    end else begin
                        state_d    = ST_RD;
                        src_d      = src_addr;
                        dst_d      = dst_addr;
                        len_d      = len;
                        idx_d      = '0;
                        xsum_d     = '0;
                        busy_d     = 1'b1;
                        ram_addr_d = src_addr;
                    end
                end
            end
            ST_RD: begin
                state_d = ST_CAP;
            end
            ST_CAP: begin
                state_d    = ST_WR;
                data_d     = ram_dout;
                xsum_d     = xsum_q ^ ram_dout;
                ram_addr_d = wr_addr;
                ram_we_d   = 1'b1;
            end
            ST_WR: begin
                idx_d = idx_next;
                if (idx_next < len_q) begin
                    state_d    = ST_RD;
                    ram_addr_d = rd_addr_next;
                end else begin
                    state_d    = ST_DONE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    checksum_d = xsum_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            xsum_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            checksum_q <= '0;
            ram_addr_q <= '0;
            ram_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            len_q      <= len_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            xsum_q     <= xsum_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            checksum_q <= checksum_d;
            ram_addr_q <= ram_addr_d;
            ram_we_q   <= ram_we_d;
        end
    end

    // The data register only changes on the CAP->WR edge, so it doubles as ram_din
    // and naturally holds its value outside WR.
    assign busy     = busy_q;
    assign done     = done_q;
    assign checksum = checksum_q;
    assign ram_addr = ram_addr_q;
    assign ram_we   = ram_we_q;
    assign ram_din  = data_q;

endmodule

// File: doc/dpram_copy_engine.md
DPRAM_COPY_ENGINE -- requirements
Module: dpram_copy_engine

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 8, as the width of one RAM data word.
REQ-002 The block SHALL take parameter ADDR_WIDTH, default 4, as the width of the RAM address, giving 2^ADDR_WIDTH words.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port start, input, 1 bit: copy request, sampled only in IDLE.
REQ-007 Port src_addr, input, ADDR_WIDTH bits: first source word address, latched on an accepted start.
REQ-008 Port dst_addr, input, ADDR_WIDTH bits: first destination word address, latched on an accepted start.
REQ-009 Port len, input, ADDR_WIDTH+1 bits: word count, 0..2^ADDR_WIDTH, latched on an accepted start.
REQ-010 Port busy, output, 1 bit: high while in RD, CAP or WR.
REQ-011 Port done, output, 1 bit: one-cycle completion pulse.
REQ-012 Port checksum, output, DATA_WIDTH bits: XOR of all words copied by the last completed job.
REQ-013 Port ram_addr, output, ADDR_WIDTH bits: address driven to one synchronous-read RAM port.
REQ-014 Port ram_we, output, 1 bit: write enable to that RAM port.
REQ-015 Port ram_din, output, DATA_WIDTH bits: write data to that RAM port.
REQ-016 Port ram_dout, input, DATA_WIDTH bits: read data from that RAM port, valid one cycle after its address.

Function
REQ-017 The FSM SHALL have the states IDLE, RD, CAP, WR and DONE, with all RAM-side outputs a function of registered state only.
REQ-018 In IDLE, start=1 with len>0 SHALL latch src_addr, dst_addr and len, clear the word index and running XOR, and enter RD.
REQ-019 In IDLE, start=1 with len=0 SHALL enter DONE directly, make no RAM access, and set checksum to 0.
REQ-020 In RD, the block SHALL drive ram_addr=src+index with ram_we=0, then enter CAP.
REQ-021 In CAP, the block SHALL capture ram_dout into the data register, XOR it into the running checksum, hold ram_we=0, then enter WR.
REQ-022 In WR, the block SHALL drive ram_addr=dst+index, ram_din=data register and ram_we=1, then increment index.
REQ-023 From WR, the block SHALL enter RD if the incremented index is below len, otherwise enter DONE.
REQ-024 In DONE, the block SHALL assert done=1 for exactly one cycle, load checksum from the running XOR, and return to IDLE.
REQ-025 Address arithmetic SHALL be modulo 2^ADDR_WIDTH, so src+index and dst+index wrap from 2^ADDR_WIDTH-1 to 0.
REQ-026 Words SHALL be copied in ascending index order, with no detection or correction of src/dst overlap.
REQ-027 Latency: with start accepted at edge E0, for len=N>0 the last write SHALL occur in cycle 3N and done SHALL be high in cycle 3N+1.
REQ-028 Latency: for len=0, done SHALL be high in cycle 1.
REQ-029 start SHALL be ignored outside IDLE, including in DONE, and input changes during a job SHALL have no effect.
REQ-030 When not in WR, ram_we SHALL be 0 and ram_din SHALL hold its last value.
REQ-031 ram_addr SHALL hold its last value in IDLE and DONE.

Reset
REQ-032 rst_n=0 SHALL, asynchronously, force state=IDLE, busy=0, done=0, ram_we=0, ram_addr=0, ram_din=0, checksum=0, and clear index, the latched fields, the data register and the running XOR.
REQ-033 Reset asserted mid-job SHALL abort the job immediately, with no further RAM writes and no done pulse.
REQ-034 After reset deasserts, the block SHALL accept a new start on the first rising edge.

Verification
REQ-035 Directed scenario: RAM[2..4]={0x11,0x22,0x44}, start with src=2, dst=8, len=3 -> RAM[8..10]={0x11,0x22,0x44}; done high in cycle 10; checksum=0x77; busy high in cycles 1-9.
REQ-036 Directed scenario: src=14, dst=0, len=4 with RAM[14,15,0,1]={A,B,C,D} -> reads at addresses 14,15,0,1 and writes at addresses 0,1,2,3 in order; RAM[0..3]={A,B,A,B}, showing ascending-order overlap behaviour.
REQ-037 Directed scenario: len=0 -> done in cycle 1, ram_we never asserted, checksum=0.
REQ-038 Directed scenario: len=16, src=0, dst=0 -> 16 writes with data equal to the prior contents, done in cycle 49, checksum=XOR of all 16 words.
REQ-039 Directed scenario: rst_n pulsed low during the CAP state of the second word -> outputs go to reset values immediately; only the first word has been written; no done pulse.
REQ-040 Directed scenario: start held high continuously -> a new job starts only in the cycle after DONE, with its RD in the cycle after that.
